bk_sector_server: RTL
=====================

# bk_sector_server

Responder end of the backup-RAM sector handshake driven by the core's save/load sequencer. It accepts `sd_rd`/`sd_wr` requests on `sd_lba` and returns the `sd_ack` acknowledge. It streams 256 16-bit words per sector over the `sd_buff_*` bus, reading from or writing to a backing word store through a toggle req/ack memory port. It sits between the save/load sequencer and the DDR-backed save store; standalone benches use it as a stand-in for the host side.

## Interface
Parameters:
- `LBA_BITS`, 7: sector index width. Store holds 2^LBA_BITS sectors of 512 bytes.
- `ACK_DELAY`, 4: cycles between request capture and `sd_ack` rise. Range 1..255.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `sd_lba` in 32: sector number, sampled at request capture.
- `sd_rd` in 1: read request (store → core), level.
- `sd_wr` in 1: write request (core → store), level.
- `sd_ack` out 1: transfer-in-progress acknowledge.
- `sd_buff_addr` out 8: word index within sector.
- `sd_buff_dout` out 16: read data to core.
- `sd_buff_wr` out 1: one-cycle strobe; `sd_buff_dout`/`sd_buff_addr` valid.
- `sd_buff_din` in 16: write data from core, valid 1 cycle after `sd_buff_addr` changes.
- `mem_addr` out LBA_BITS+8: store word address, {lba, word}.
- `mem_wdata` out 16: store write data.
- `mem_we` out 1: 1 = write, 0 = read; stable while request outstanding.
- `mem_req` out 1: toggles to issue an access.
- `mem_ack` in 1: access complete when equal to `mem_req`; `mem_rdata` valid then.
- `mem_rdata` in 16: store read data.
- `busy` out 1: high from capture until return to IDLE.
- `err` out 1: last captured LBA was out of range; sticky until next capture.

## Operation
- States: IDLE, ACKDLY, RD_REQ, RD_WAIT, RD_PUT, WR_ADDR, WR_CAP, WR_WAIT, FINISH.
- IDLE → ACKDLY when `sd_rd|sd_wr`.
  - Latch lba and direction. If both requests are high, read wins.
  - Clear word counter; set `err` = (`sd_lba` ≥ 2^LBA_BITS).
- ACKDLY: count ACK_DELAY, then raise `sd_ack` and enter RD_REQ or WR_ADDR.
  - The initiator drops its request on the `sd_ack` rise; the server ignores request levels outside IDLE.
- Read path:
  - RD_REQ: toggle `mem_req`, `mem_we`=0.
  - RD_WAIT: wait until `mem_ack`==`mem_req`.
  - RD_PUT: drive `sd_buff_addr`=word and `sd_buff_dout`=`mem_rdata`, pulse `sd_buff_wr`. Increment word; after word 255 go to FINISH, else RD_REQ.
  - If `err`: skip memory; `sd_buff_dout`=16'hFFFF.
- Write path:
  - WR_ADDR: drive `sd_buff_addr`=word.
  - WR_CAP: capture `sd_buff_din` into `mem_wdata`, toggle `mem_req`, `mem_we`=1.
  - WR_WAIT: wait for ack match. Increment word; after word 255 go to FINISH, else WR_ADDR.
  - If `err`: discard data, no `mem_req` toggle.
- FINISH: drop `sd_ack` and `busy`, go to IDLE.
  - The next request is accepted from the following cycle. This covers the sequencer raising its next request one cycle after the ack fall.
- Word counter is 8 bits; wrap 255→0 marks end of sector.
- Reset, including mid-transfer: state IDLE; all outputs 0 (`sd_ack`, `sd_buff_wr`, `sd_buff_addr`, `sd_buff_dout`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `err`).
  - The store's ack toggle must be reset by the same `reset`.

## Timing
- Request high at cycle N: `busy` at N+1, `sd_ack` at N+1+ACK_DELAY.
- Read word with store latency L cycles: toggle → match in L, then `sd_buff_wr` one cycle after match. Minimum 3 cycles/word at L=1.
- Write word: addr cycle, capture+toggle cycle, wait ≥1. Minimum 3 cycles/word.
- `sd_buff_wr` is never high for two consecutive cycles.
- `mem_req` toggles only when `mem_ack`==`mem_req`.
- `sd_ack` falls exactly one cycle after the last word completes.

## Structure
- Package `bk_pkg`:
  - state enum `bk_state_t`;
  - `SECTOR_WORDS`=256;
  - `OOR_FILL`=16'hFFFF.
- No sub-module. The memory toggle handshake and ack delay are inline counters and registers in this single module.

## Test plan
- Read sector 0, store model with L=2 and data=addr^16'h5A5A:
  - 256 `sd_buff_wr` strobes, addr 0..255, word 3 = 16'h5A59;
  - `sd_ack` high N+5..last+1.
- Write sector 5, `sd_buff_din`=~addr:
  - store words 0x500..0x5FF hold ~addr;
  - exactly 256 `mem_req` toggles, all with `mem_we`=1.
- Sequencer loop of 128 reads (lba 0..127), request re-raised 1 cycle after each ack fall:
  - all 128 served in order;
  - 32768 strobes total, no lost request.
- Read lba 200 with LBA_BITS=7:
  - `err`=1, 256 strobes of 16'hFFFF, zero `mem_req` toggles.
  - Then a valid write clears `err`.
- `sd_rd` and `sd_wr` high in the same cycle: read transfer only, no writes to store.
- Assert `reset` during word 100 of a write, release, then request a read of sector 1:
  - all outputs 0 during reset;
  - read completes normally with 256 strobes;
  - store words 100..255 of the interrupted sector are unchanged.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM sector server.
//   bk_state_t   - transfer state machine encoding
//   SECTOR_WORDS - 16-bit words per 512-byte sector
//   OOR_FILL     - word returned for reads of out-of-range sectors
package bk_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ACKDLY,
    RD_REQ,
    RD_WAIT,
    RD_PUT,
    WR_ADDR,
    WR_CAP,
    WR_WAIT,
    FINISH
  } bk_state_t;

  localparam int          SECTOR_WORDS = 256;
  localparam logic [15:0] OOR_FILL     = 16'hFFFF;

endpackage

// File: rtl/bk_sector_server.sv
// Responder side of the backup-RAM sector handshake.
// A sd_rd/sd_wr level request on sd_lba is acknowledged with sd_ack after
// ACK_DELAY cycles, then 256 words stream over the sd_buff_* bus. Each word
// is read from or written to a backing store through a toggle req/ack port.
//
// Ports:
//   clk_sys, reset          - clock, asynchronous active-high reset
//   sd_lba, sd_rd, sd_wr    - request: sector number, read / write level
//   sd_ack                  - transfer in progress
//   sd_buff_addr/dout/wr    - word index, read data, one-cycle data strobe
//   sd_buff_din             - write data, valid one cycle after addr changes
//   mem_addr/wdata/we       - store word address {lba, word}, data, direction
//   mem_req / mem_ack       - toggle handshake, done when equal
//   mem_rdata               - store read data, valid when ack matches req
//   busy                    - capture to return to IDLE
//   err                     - last captured sector was out of range (sticky)
module bk_sector_server
  import bk_pkg::*;
#(
  parameter int LBA_BITS  = 7,
  parameter int ACK_DELAY = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [31:0]           sd_lba,
  input  logic                  sd_rd,
  input  logic                  sd_wr,
  output logic                  sd_ack,
  output logic [7:0]            sd_buff_addr,
  output logic [15:0]           sd_buff_dout,
  output logic                  sd_buff_wr,
  input  logic [15:0]           sd_buff_din,
  output logic [LBA_BITS+7:0]   mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_rdata,
  output logic                  busy,
  output logic                  err
);

  bk_state_t             state, state_nxt;
  logic                  is_rd;
  logic [LBA_BITS-1:0]   lba;
  logic [7:0]            word;
  logic [7:0]            dly_cnt;
  logic                  req_any;
  logic                  mem_match;
  logic                  dly_done;
  logic                  word_last;

  assign req_any   = sd_rd | sd_wr;
  assign mem_match = (mem_ack == mem_req);
  assign dly_done  = (dly_cnt == 8'(ACK_DELAY - 1));
  assign word_last = (word == 8'(SECTOR_WORDS - 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = ACKDLY;
      ACKDLY:  if (dly_done) state_nxt = is_rd ? RD_REQ : WR_ADDR;
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: if (mem_match) state_nxt = RD_PUT;
      RD_PUT:  state_nxt = word_last ? FINISH : RD_REQ;
      WR_ADDR: state_nxt = WR_CAP;
      WR_CAP:  state_nxt = WR_WAIT;
      WR_WAIT: if (mem_match) state_nxt = word_last ? FINISH : WR_ADDR;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read-side toggles are issued on entry to RD_REQ so a store with one
  // cycle of latency matches in RD_WAIT's first cycle (3 cycles per word).
  // With err set the store is never touched: no toggle means the ack still
  // matches, so the wait states fall straight through.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      is_rd        <= 1'b0;
      lba          <= '0;
      word         <= '0;
      dly_cnt      <= '0;
      sd_ack       <= 1'b0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      sd_buff_wr   <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      mem_req      <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      sd_buff_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            is_rd   <= sd_rd;
            lba     <= sd_lba[LBA_BITS-1:0];
            err     <= ((sd_lba >> LBA_BITS) != 32'd0);
            word    <= '0;
            dly_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ACKDLY: begin
          dly_cnt <= dly_cnt + 8'd1;
          if (dly_done) begin
            sd_ack       <= 1'b1;
            sd_buff_addr <= '0;
            if (is_rd && !err) begin
              mem_req  <= ~mem_req;
              mem_we   <= 1'b0;
              mem_addr <= {lba, word};
            end
          end
        end
        RD_WAIT: begin
          if (mem_match) begin
            sd_buff_wr   <= 1'b1;
            sd_buff_addr <= word;
            sd_buff_dout <= err ? OOR_FILL : mem_rdata;
          end
        end
        RD_PUT: begin
          word <= word + 8'd1;
          if (word_last) begin
            sd_ack <= 1'b0;
            busy   <= 1'b0;
          end else if (!err) begin
            mem_req  <= ~mem_req;
            mem_we   <= 1'b0;
            mem_addr <= {lba, word + 8'd1};
          end
        end
        WR_CAP: begin
          if (!err) begin
            mem_wdata <= sd_buff_din;
            mem_req   <= ~mem_req;
            mem_we    <= 1'b1;
            mem_addr  <= {lba, word};
          end
        end
        WR_WAIT: begin
          if (mem_match) begin
            word <= word + 8'd1;
            if (word_last) begin
              sd_ack <= 1'b0;
              busy   <= 1'b0;
            end else begin
              sd_buff_addr <= word + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
